// File: rtl/serial_add_if.sv
// Handshake and data bundle between two adder clients and serial_add_arbiter.
// The master side drives requests and operands; the slave side returns
// grants, status and the registered result.
interface serial_add_if #(
    parameter int WIDTH = 8
);
    logic             req0;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic             req1;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic [1:0]       gnt;
    logic             busy;
    logic             done;
    logic             done_id;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output req0, a0, b0, req1, a1, b1,
        input  gnt, busy, done, done_id, sum, cout
    );

    modport slave (
        input  req0, a0, b0, req1, a1, b1,
        output gnt, busy, done, done_id, sum, cout
    );
endinterface

// File: rtl/serial_add_arbiter.sv
// Bit-serial WIDTH-bit adder shared by two requesters under round-robin
// arbitration. One 1-bit cell (two half-adder stages plus a carry flop)
// is stepped WIDTH times per operation, LSB first.
// Optional build macro: SERIAL_ADD_SAT_EN -- when defined, a result with a
// carry out of the MSB saturates sum to all ones (cout still reports 1).
module serial_add_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    serial_add_if.slave bus
);
    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             last_id;

    logic             accept_id;
    logic             s1;
    logic             c1;
    logic             c2;
    logic             sum_bit;
    logic [WIDTH-1:0] final_sum;

    // Arbitration choice, the shared 1-bit cell, and the result as published.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        accept_id = bus.req1;
        if (bus.req0 && bus.req1) begin
            accept_id = ~last_id;
        end

        s1      = a_sr[0] ^ b_sr[0];
        c1      = a_sr[0] & b_sr[0];
        sum_bit = s1 ^ carry;
        c2      = s1 & carry;

        final_sum = sum_sr;
`ifdef SERIAL_ADD_SAT_EN
        if (carry) begin
            final_sum = '1;
        end
`endif
    end

    // Controller, datapath shift registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the shift registers are ordinary flops, not a memory, so
        // they are cleared here along with the rest of the state.
        if (!rst_n) begin
            state       <= IDLE;
            a_sr        <= '0;
            b_sr        <= '0;
            sum_sr      <= '0;
            carry       <= 1'b0;
            cnt         <= '0;
            last_id     <= 1'b1;
            bus.gnt     <= 2'b00;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.done_id <= 1'b0;
            bus.sum     <= '0;
            bus.cout    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values regardless of statement order.
            bus.gnt  <= 2'b00;
            bus.done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.req0 || bus.req1) begin
                        a_sr     <= accept_id ? bus.a1 : bus.a0;
                        b_sr     <= accept_id ? bus.b1 : bus.b0;
                        carry    <= 1'b0;
                        cnt      <= '0;
                        last_id  <= accept_id;
                        bus.gnt  <= accept_id ? 2'b10 : 2'b01;
                        bus.busy <= 1'b1;
                        state    <= ADD;
                    end
                end
                ADD: begin
                    carry  <= c1 | c2;
                    sum_sr <= {sum_bit, sum_sr[WIDTH-1:1]};
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST_BIT) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    bus.done    <= 1'b1;
                    bus.done_id <= last_id;
                    bus.sum     <= final_sum;
                    bus.cout    <= carry;
                    bus.busy    <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
